// File: rtl/id_inst_queue.sv
// id_inst_queue: fetch-to-decode instruction queue.
// A DEPTH-entry circular FIFO of {excepttype, pc, inst} between the I-cache
// return and the decode register. It lets fetch run ahead while decode stalls.
// Optional feature macro: ID_IQ_BYPASS_EN. When it is defined, an entry arriving
// at an empty queue is shown to decode in the same cycle.
module id_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       br_kill,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [EXC_W-1:0]           in_excepttype,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [EXC_W-1:0]           out_excepttype,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [EXC_W-1:0]  mem_exc  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic head_valid;
    logic byp;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // count is held apart from the pointers, so full and empty are never ambiguous
    assign head_valid = (count != '0);
    assign in_ready   = (count != FULL_CNT);

`ifdef ID_IQ_BYPASS_EN
    // Flush and br_kill do not gate this path. They only cancel the write.
    assign byp = (count == '0) & in_valid;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = head_valid | byp;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // A bypassed entry that decode takes at once is never written.
    assign wr_en     = push & ~(byp & out_ready);
    assign rd_en     = pop & head_valid;

    // Head entry, or the bypassed input, or a bubble (all zero) when nothing is valid.
    always_comb begin
        out_pc         = '0;
        out_inst       = '0;
        out_excepttype = '0;
        if (head_valid) begin
            out_pc         = mem_pc[rd_ptr];
            out_inst       = mem_inst[rd_ptr];
            out_excepttype = mem_exc[rd_ptr];
        end else if (byp) begin
            out_pc         = in_pc;
            out_inst       = in_inst;
            out_excepttype = in_excepttype;
        end
    end

    // Storage write. Stale contents are harmless because the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]   <= in_pc;
            mem_inst[wr_ptr] <= in_inst;
            mem_exc[wr_ptr]  <= in_excepttype;
        end
    end

    // Pointer and occupancy update. Priority is rst, then flush or br_kill, then push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush | br_kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue. A queue-based reference model is checked against
// the DUT at every negedge, and directed scenarios add literal expectations.
module tb_id_inst_queue;

    localparam int DEPTH = 4;
`ifdef ID_IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        br_kill = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_excepttype = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_excepttype;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] log_pc[$];

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .br_kill(br_kill),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .in_excepttype(in_excepttype),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_excepttype(out_excepttype), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] exc_of(input logic [31:0] pc);
        return {28'h0, pc[5:2]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs come from the model queue and the current inputs.
    function automatic bit m_byp();
        return BYP && (q.size() == 0) && in_valid;
    endfunction

    function automatic bit m_valid();
        return (q.size() != 0) || m_byp();
    endfunction

    function automatic ent_t m_head();
        ent_t e;
        e.pc = '0; e.inst = '0; e.exc = '0;
        if (q.size() != 0) e = q[0];
        else if (m_byp()) begin
            e.pc = in_pc; e.inst = in_inst; e.exc = in_excepttype;
        end
        return e;
    endfunction

    // Model state update at each clock edge.
    int   m_n;
    bit   m_b;
    ent_t m_e;
    always @(posedge clk) begin
        if (rst || flush || br_kill) begin
            q.delete();
        end else begin
            m_n = q.size();
            m_b = m_byp();
            if (m_valid() && out_ready) begin
                if (m_n != 0) begin
                    m_e = q.pop_front();
                    log_pc.push_back(m_e.pc);
                end else begin
                    log_pc.push_back(in_pc);
                end
            end
            if (in_valid && m_n < DEPTH && !(m_b && out_ready)) begin
                m_e.pc = in_pc; m_e.inst = in_inst; m_e.exc = in_excepttype;
                q.push_back(m_e);
            end
        end
    end

    // Compare process: every cycle after reset, at the falling edge.
    ent_t h;
    always @(negedge clk) begin
        if (chk_en) begin
            h = m_head();
            check("count",     {61'd0, count}, 64'(q.size()));
            check("in_ready",  {63'd0, in_ready}, {63'd0, (q.size() != DEPTH)});
            check("out_valid", {63'd0, out_valid}, {63'd0, m_valid()});
            check("out_pc",    {32'd0, out_pc}, {32'd0, h.pc});
            check("out_inst",  {32'd0, out_inst}, {32'd0, h.inst});
            check("out_exc",   {32'd0, out_excepttype}, {32'd0, h.exc});
        end
    end

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; br_kill = 1'b0;
        in_pc = '0; in_inst = '0; in_excepttype = '0;
    endtask

    // One clock cycle with the given inputs; inputs return to idle 1ns after the edge.
    task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy,
                       input bit fl, input bit bk);
        in_valid = v; in_pc = pc; in_inst = inst_of(pc); in_excepttype = exc_of(pc);
        out_ready = rdy; flush = fl; br_kill = bk;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", {32'd0, out_pc}, 64'd0);
        check("rst_out_inst", {32'd0, out_inst}, 64'd0);
        check("rst_out_exc", {32'd0, out_excepttype}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Fill to full, try a fifth entry, then drain in order
        for (int i = 0; i < 4; i++) cyc(1, 32'hBFC0_0000 + 32'(4 * i), 0, 0, 0);
        check("fill_count", {61'd0, count}, 64'd4);
        check("fill_in_ready", {63'd0, in_ready}, 64'd0);
        cyc(1, 32'hBFC0_0010, 0, 0, 0);
        check("full_reject_count", {61'd0, count}, 64'd4);
        check("full_head_pc", {32'd0, out_pc}, 64'hBFC0_0000);
        log_pc.delete();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        check("drain_n", 64'(log_pc.size()), 64'd4);
        if (log_pc.size() == 4) begin
            check("drain_pc0", {32'd0, log_pc[0]}, 64'hBFC0_0000);
            check("drain_pc1", {32'd0, log_pc[1]}, 64'hBFC0_0004);
            check("drain_pc2", {32'd0, log_pc[2]}, 64'hBFC0_0008);
            check("drain_pc3", {32'd0, log_pc[3]}, 64'hBFC0_000C);
        end
        check("drain_count", {61'd0, count}, 64'd0);

        // Sustained push+pop at count 2 across pointer wrap
        cyc(1, 32'h0000_1000, 0, 0, 0);
        cyc(1, 32'h0000_1004, 0, 0, 0);
        log_pc.delete();
        for (int i = 0; i < 10; i++) cyc(1, 32'h0000_1008 + 32'(4 * i), 1, 0, 0);
        check("pp_count", {61'd0, count}, 64'd2);
        check("pp_n", 64'(log_pc.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            if (i < log_pc.size())
                check("pp_seq", {32'd0, log_pc[i]}, 64'h1000 + 64'(4 * i));
        check("pp_head_pc", {32'd0, out_pc}, 64'h1028);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Flush at count 3 with a same-cycle push
        cyc(1, 32'h0000_2000, 0, 0, 0);
        cyc(1, 32'h0000_2004, 0, 0, 0);
        cyc(1, 32'h0000_2008, 0, 0, 0);
        check("pre_flush_count", {61'd0, count}, 64'd3);
        log_pc.delete();
        cyc(1, 32'h0000_200C, 0, 1, 0);
        check("flush_count", {61'd0, count}, 64'd0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_out_inst", {32'd0, out_inst}, 64'd0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("flush_nothing_out", 64'(log_pc.size()), 64'd0);

        // br_kill at count 2 with a same-cycle push and pop
        cyc(1, 32'h0000_3000, 0, 0, 0);
        cyc(1, 32'h0000_3004, 0, 0, 0);
        cyc(1, 32'h0000_3008, 1, 0, 1);
        check("kill_count", {61'd0, count}, 64'd0);
        check("kill_out_valid", {63'd0, out_valid}, 64'd0);
        log_pc.delete();
        cyc(1, 32'h0000_4000, 0, 0, 0);
        check("kill_next_pc", {32'd0, out_pc}, 64'h4000);
        cyc(0, 0, 1, 0, 0);
        check("kill_first_n", 64'(log_pc.size()), 64'd1);
        if (log_pc.size() == 1) check("kill_first_pc", {32'd0, log_pc[0]}, 64'h4000);

        // Empty queue with simultaneous input and consumer
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = inst_of(32'h8000_0000);
        in_excepttype = exc_of(32'h8000_0000); out_ready = 1'b1;
        #1;
        check("byp_same_valid", {63'd0, out_valid}, {63'd0, BYP});
        check("byp_same_pc", {32'd0, out_pc}, BYP ? 64'h8000_0000 : 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        check("byp_next_count", {61'd0, count}, BYP ? 64'd0 : 64'd1);
        check("byp_next_pc", {32'd0, out_pc}, BYP ? 64'd0 : 64'h8000_0000);
        cyc(0, 0, 1, 0, 0);
        check("end_count", {61'd0, count}, 64'd0);

        // Reset in the middle of operation
        cyc(1, 32'h0000_5000, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_count", {61'd0, count}, 64'd0);
        cyc(0, 0, 0, 0, 0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
